// File: rtl/field_packer.sv
// ============================================================================
// field_packer
//
// Purpose:
//   Streams variable-length bit fields, each replicated rep times, into
//   OUT_W-bit words MSB-first ({rep{data[len-1:0]}}). A word is emitted over
//   a valid/ready handshake when it fills, or early (partially filled) when a
//   field carrying the flush flag has been fully appended.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous active-low reset
//   in_valid   - a field is offered
//   in_ready   - block can accept a field (IDLE and not in reset)
//   in_data    - field bits, only the len LSBs are used
//   in_len     - field length in bits, values above IN_W clamp to IN_W
//   in_rep     - number of copies of the field
//   in_flush   - emit any partial word once this field is appended
//   out_valid  - packed word available
//   out_ready  - sink accepts the word
//   out_data   - packed word, left-justified, unused LSBs are 0
//   out_bits   - number of valid MSBs in out_data
// ============================================================================
module field_packer #(
    parameter int OUT_W = 12,
    parameter int IN_W  = 4,
    parameter int REP_W = 3,
    localparam int LEN_W  = $clog2(IN_W + 1),
    localparam int FILL_W = $clog2(OUT_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic [LEN_W-1:0]  in_len,
    input  logic [REP_W-1:0]  in_rep,
    input  logic              in_flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [FILL_W-1:0] out_bits
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_EMIT   = 2'd2;

    localparam logic [FILL_W-1:0] FULL    = FILL_W'(OUT_W);
    localparam logic [LEN_W-1:0]  LEN_MAX = LEN_W'(IN_W);

    // State and datapath registers
    logic [1:0]        state_q,     state_d;
    logic [OUT_W-1:0]  acc_q,       acc_d;
    logic [FILL_W-1:0] fill_q,      fill_d;
    logic [IN_W-1:0]   data_q,      data_d;
    logic [LEN_W-1:0]  len_q,       len_d;
    logic [LEN_W-1:0]  bits_left_q, bits_left_d;
    logic [REP_W-1:0]  copies_q,    copies_d;
    logic              flush_q,     flush_d;
    logic              out_valid_q, out_valid_d;
    logic [OUT_W-1:0]  out_data_q,  out_data_d;
    logic [FILL_W-1:0] out_bits_q,  out_bits_d;

    // Combinational helpers
    logic [LEN_W-1:0]  len_clamped_s;
    logic [FILL_W-1:0] bits_left_w_s;
    logic [FILL_W-1:0] room_s;
    logic [FILL_W-1:0] take_s;
    logic [OUT_W-1:0]  data_ext_s;
    logic [OUT_W-1:0]  chunk_s;
    logic [OUT_W-1:0]  placed_s;
    logic [LEN_W-1:0]  bits_left_nxt_s;
    logic              copy_done_s;
    logic              all_done_s;

    assign in_ready  = (state_q == ST_IDLE) && rst_n;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_bits  = out_bits_q;

    // Length clamp for an incoming field
    always_comb begin
        len_clamped_s = in_len;
        if (in_len > LEN_MAX) begin
            len_clamped_s = LEN_MAX;
        end else begin
            len_clamped_s = in_len;
        end
    end

    // Slice the next chunk of the current copy and align it below the fill point.
    // The chunk is the top take_s bits of the remaining copy bits; its LSB lands
    // at bit (room - take) of the accumulator, i.e. acc[OUT_W-1-fill -: take].
    always_comb begin
        bits_left_w_s   = FILL_W'(bits_left_q);
        room_s          = FULL - fill_q;
        take_s          = (bits_left_w_s < room_s) ? bits_left_w_s : room_s;
        data_ext_s      = OUT_W'(data_q);
        chunk_s         = (data_ext_s >> (bits_left_w_s - take_s))
                          & ~({OUT_W{1'b1}} << take_s);
        placed_s        = chunk_s << (room_s - take_s);
        bits_left_nxt_s = bits_left_q - LEN_W'(take_s);
        copy_done_s     = (bits_left_nxt_s == '0);
        all_done_s      = copy_done_s && (copies_q == REP_W'(1));
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        fill_d      = fill_q;
        data_d      = data_q;
        len_d       = len_q;
        bits_left_d = bits_left_q;
        copies_d    = copies_q;
        flush_d     = flush_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d      = in_data;
                    len_d       = len_clamped_s;
                    bits_left_d = len_clamped_s;
                    flush_d     = in_flush;
                    // A zero-length field carries no copies; clearing the
                    // counter keeps a flush-triggered EMIT from resuming EXPAND.
                    if (len_clamped_s == '0) begin
                        copies_d = '0;
                    end else begin
                        copies_d = in_rep;
                    end
                    if ((len_clamped_s != '0) && (in_rep != '0)) begin
                        state_d = ST_EXPAND;
                    end else if (in_flush && (fill_q != '0)) begin
                        state_d = ST_EMIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_EXPAND: begin
                acc_d  = acc_q | placed_s;
                fill_d = fill_q + take_s;
                if (copy_done_s) begin
                    copies_d    = copies_q - REP_W'(1);
                    bits_left_d = len_q;
                end else begin
                    bits_left_d = bits_left_nxt_s;
                end
                // A full word always goes out first, even on the last copy.
                if (fill_d == FULL) begin
                    state_d = ST_EMIT;
                end else if (all_done_s) begin
                    if (flush_q && (fill_d != '0)) begin
                        state_d = ST_EMIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_EXPAND;
                end
            end

            ST_EMIT: begin
                if (out_ready) begin
                    acc_d  = '0;
                    fill_d = '0;
                    // copies_q counts copies not yet fully appended, including
                    // one split across the word boundary.
                    if (copies_q != '0) begin
                        state_d = ST_EXPAND;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output register next values: capture the word on entry to EMIT,
    // hold it while stalled, clear it once the sink takes it.
    always_comb begin
        out_valid_d = (state_d == ST_EMIT);
        out_data_d  = out_data_q;
        out_bits_d  = out_bits_q;
        if ((state_d == ST_EMIT) && (state_q != ST_EMIT)) begin
            out_data_d = acc_d;
            out_bits_d = fill_d;
        end else if (out_valid_q && out_ready) begin
            out_data_d = '0;
            out_bits_d = '0;
        end else begin
            out_data_d = out_data_q;
            out_bits_d = out_bits_q;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            fill_q      <= '0;
            data_q      <= '0;
            len_q       <= '0;
            bits_left_q <= '0;
            copies_q    <= '0;
            flush_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_bits_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            data_q      <= data_d;
            len_q       <= len_d;
            bits_left_q <= bits_left_d;
            copies_q    <= copies_d;
            flush_q     <= flush_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_bits_q  <= out_bits_d;
        end
    end

endmodule

// File: tb/tb_field_packer.sv
// ============================================================================
// tb_field_packer
//
// Directed-vector bench for field_packer (OUT_W=12, IN_W=4, REP_W=3).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Every accepted output word is logged by a monitor and
// compared against hand-computed values.
// ============================================================================
module tb_field_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic [2:0]  in_len;
    logic [2:0]  in_rep;
    logic        in_flush;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic [3:0]  out_bits;

    int checks   = 0;
    int failures = 0;

    logic [11:0] q_data[$];
    logic [3:0]  q_bits[$];
    int          valid_cycles = 0;

    field_packer #(
        .OUT_W (12),
        .IN_W  (4),
        .REP_W (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_len    (in_len),
        .in_rep    (in_rep),
        .in_flush  (in_flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_bits  (out_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every word handed to the sink, and count cycles with out_valid high
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_bits.push_back(out_bits);
        end
        if (out_valid) begin
            valid_cycles++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer one field and hold it until accepted (bounded wait)
    task automatic push(input logic [3:0] d, input logic [2:0] l,
                        input logic [2:0] r, input logic f);
        int n;
        n        = 0;
        in_data  = d;
        in_len   = l;
        in_rep   = r;
        in_flush = f;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("push_accept", 32'(n < 200), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_flush = 1'b0;
    endtask

    // Wait until the block is idle with no word pending (bounded wait)
    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!(in_ready && !out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_idle"}, 32'(n < 500), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Wait until out_valid is seen on a falling edge (bounded wait)
    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_valid"}, 32'(n < 500), 32'd1);
    endtask

    // Field sequence that packs exactly to 12'hFA2
    task automatic scen1_fields();
        push(4'b0011, 3'd2, 3'd1, 1'b0);
        push(4'b0001, 3'd1, 3'd3, 1'b0);
        push(4'b0000, 3'd1, 3'd1, 1'b0);
        push(4'b1000, 3'd4, 3'd1, 1'b0);
        push(4'b0010, 3'd2, 3'd1, 1'b0);
    endtask

    initial begin
        int base;
        int v0;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        in_len    = 3'd0;
        in_rep    = 3'd0;
        in_flush  = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready",  32'(in_ready),  32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data",  32'(out_data),  32'd0);
        check_eq("rst_out_bits",  32'(out_bits),  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Degenerate fields: len 0 / rep 0, flush with nothing buffered
        base = q_data.size();
        v0   = valid_cycles;
        push(4'b1111, 3'd0, 3'd5, 1'b1);
        @(negedge clk);
        check_eq("s5_len0_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        push(4'b0101, 3'd3, 3'd0, 1'b1);
        @(negedge clk);
        check_eq("s5_rep0_ready", 32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("s5_no_valid", 32'(valid_cycles - v0), 32'd0);
        check_eq("s5_no_words", 32'(q_data.size() - base), 32'd0);
        @(posedge clk);
        #1;

        // Scenario 1: one full word without flush
        base = q_data.size();
        scen1_fields();
        wait_idle("s1");
        check_eq("s1_count", 32'(q_data.size() - base), 32'd1);
        check_eq("s1_data",  32'(q_data[base]), 32'h0FA2);
        check_eq("s1_bits",  32'(q_bits[base]), 32'd12);

        // Scenario 2: copy split across a word boundary, then flush
        base = q_data.size();
        push(4'b0000, 3'd4, 3'd2, 1'b0);
        push(4'b0000, 3'd2, 3'd1, 1'b0);
        push(4'b1011, 3'd4, 3'd1, 1'b1);
        wait_idle("s2");
        check_eq("s2_count",  32'(q_data.size() - base), 32'd2);
        check_eq("s2_data0",  32'(q_data[base]),     32'h0002);
        check_eq("s2_bits0",  32'(q_bits[base]),     32'd12);
        check_eq("s2_data1",  32'(q_data[base + 1]), 32'h0C00);
        check_eq("s2_bits1",  32'(q_bits[base + 1]), 32'd2);

        // Scenario 3: replication spanning two words, len clamp untouched
        base = q_data.size();
        push(4'b0101, 3'd3, 3'd7, 1'b1);
        wait_idle("s3");
        check_eq("s3_count",  32'(q_data.size() - base), 32'd2);
        check_eq("s3_data0",  32'(q_data[base]),     32'h0B6D);
        check_eq("s3_bits0",  32'(q_bits[base]),     32'd12);
        check_eq("s3_data1",  32'(q_data[base + 1]), 32'h0B68);
        check_eq("s3_bits1",  32'(q_bits[base + 1]), 32'd9);

        // Scenario 4: backpressure holds the word stable
        out_ready = 1'b0;
        base = q_data.size();
        scen1_fields();
        wait_valid("s4");
        for (int i = 0; i < 5; i++) begin
            check_eq("s4_hold_valid", 32'(out_valid), 32'd1);
            check_eq("s4_hold_data",  32'(out_data),  32'h0FA2);
            check_eq("s4_hold_ready", 32'(in_ready),  32'd0);
            @(negedge clk);
        end
        check_eq("s4_hold_bits", 32'(out_bits), 32'd12);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("s4_pre_xfer_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check_eq("s4_post_valid", 32'(out_valid), 32'd0);
        check_eq("s4_post_ready", 32'(in_ready),  32'd1);
        check_eq("s4_count", 32'(q_data.size() - base), 32'd1);
        check_eq("s4_data",  32'(q_data[base]), 32'h0FA2);
        @(posedge clk);
        #1;

        // Scenario 6: reset while a word is pending
        out_ready = 1'b0;
        base = q_data.size();
        scen1_fields();
        wait_valid("s6");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("s6_rst_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("s6_rst_valid", 32'(out_valid), 32'd0);
        check_eq("s6_rst_data",  32'(out_data),  32'd0);
        check_eq("s6_rst_bits",  32'(out_bits),  32'd0);
        check_eq("s6_rst_words", 32'(q_data.size() - base), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        scen1_fields();
        wait_idle("s6b");
        check_eq("s6_count", 32'(q_data.size() - base), 32'd1);
        check_eq("s6_data",  32'(q_data[base]), 32'h0FA2);
        check_eq("s6_bits",  32'(q_bits[base]), 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/field_packer.md
Name: field_packer

Overview:
- Sequential, parametrised successor of our combinational concatenate/replicate block.
- Accepts a stream of variable-length bit fields, each with a replication count. It builds {rep{data[len-1:0]}} MSB-first into OUT_W-bit words.
- Emits each word over a valid/ready handshake when the word fills, or on an explicit flush.
- Sits between field-generating control logic and any word-oriented sink, such as a serialiser or register file.

Parameters:
- OUT_W, 12: output word width in bits (≥2).
- IN_W, 4: maximum field width in bits (1 ≤ IN_W ≤ OUT_W).
- REP_W, 3: width of the replication count; maximum rep is 2^REP_W-1.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: synchronous active-low reset.
- in_valid, input, 1: field offered.
- in_ready, output, 1: block can accept a field.
- in_data, input, IN_W: field bits; only the len LSBs are used.
- in_len, input, $clog2(IN_W+1): field length in bits (0..IN_W; values above IN_W are clamped to IN_W).
- in_rep, input, REP_W: number of copies of the field (0..2^REP_W-1).
- in_flush, input, 1: after this field, emit any partial word.
- out_valid, output, 1: word available.
- out_ready, input, 1: sink accepts the word.
- out_data, output, OUT_W: packed word, left-justified; unused LSBs are 0.
- out_bits, output, $clog2(OUT_W+1): number of valid MSBs in out_data (OUT_W for a full word).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset: rst_n low at a rising edge forces the following, regardless of state:
  - state = IDLE
  - acc = 0, fill = 0
  - out_valid = 0, out_data = 0, out_bits = 0
  - in_ready = 0 while rst_n is low
- Reset mid-operation discards any partial word and the pending field.
- State machine: IDLE, EXPAND, EMIT.
- Output timing:
  - in_ready = (state==IDLE) && rst_n, combinational.
  - out_valid = (state==EMIT), registered.
- IDLE:
  - A field is accepted on in_valid && in_ready. The block latches data, len (clamped), rep, and flush, and loads the copy counter = rep and the bits-left counter = len.
  - Next state:
    - EXPAND if len≠0 and rep≠0.
    - Otherwise, if flush and fill>0, EMIT.
    - Otherwise IDLE.
- EXPAND:
  - Each cycle appends k = min(bits_left, OUT_W-fill) bits of the current copy, taken MSB-first from data[bits_left-1 -: k], into acc[OUT_W-1-fill -: k]. Then fill += k and bits_left -= k.
  - When bits_left reaches 0, copies is decremented and bits_left reloads to len.
  - A copy that fits takes 1 cycle. A copy split across a word boundary takes 2 EXPAND cycles plus the EMIT.
  - Exit conditions:
    - fill==OUT_W → EMIT. This has priority.
    - All copies done → EMIT if flush and fill>0, else IDLE.
- EMIT:
  - out_data = acc and out_bits = fill, both held stable while out_ready is low. No input is accepted.
  - On out_valid && out_ready: acc = 0 and fill = 0. Next state is EXPAND if copies or bits remain, else IDLE.
- Boundary conditions:
  - Last copy exactly fills the word: one EMIT with out_bits=OUT_W. A pending flush then produces no extra word.
  - Flush with fill==0: no word is emitted.
  - len=0 or rep=0: field is consumed in one cycle with no bits appended. Flush is still honoured.
- Throughput: one field per (1 + copies + splits + emit stalls) cycles. No bits are ever dropped or reordered.

Test Plan (OUT_W=12, IN_W=4, REP_W=3):
1. Fields, in order:
   - {data 4'b0011, len 2, rep 1}
   - {4'b0001, len 1, rep 3}
   - {4'b0000, len 1, rep 1}
   - {4'b1000, len 4, rep 1}
   - {4'b0010, len 2, rep 1}
   - Required response: exactly one word, out_data=12'hFA2, out_bits=12, with no flush needed.
2. Word-boundary split:
   - Pre-fill 10 bits of 0 (field 4'b0000 len 4 rep 2, then 4'b0000 len 2 rep 1).
   - Push 4'b1011 len 4 rep 1 flush=1.
   - Required response: word 12'h002 (bits 10 appended) with out_bits 12, then word 12'hC00 with out_bits 2.
3. Replication across words:
   - Push 4'b0101 len 3 rep 7 flush=1.
   - Required response: 12'hB6D with out_bits 12, then 12'hB68 with out_bits 9.
4. Backpressure:
   - Repeat scenario 1 with out_ready held low for 5 cycles once out_valid rises.
   - Required response: out_data stays 12'hFA2, out_valid stays 1, in_ready stays 0. The word transfers on the cycle out_ready rises, and in_ready returns the next cycle.
5. Degenerate fields:
   - From reset, push len 0 rep 5 flush=1, then len 3 rep 0 flush=1.
   - Required response: each is accepted in one cycle, and out_valid never asserts.
6. Reset mid-EMIT:
   - Assert rst_n=0 for one edge while out_valid=1 in scenario 4.
   - Required response: out_valid=0, out_data=0, out_bits=0 after the edge. A new scenario 1 afterwards yields a clean 12'hFA2.
